event_detector_multi: RTL
=========================

EVENT_DETECTOR_MULTI -- requirements
Module: event_detector_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth per channel (>=2).
REQ-003 Parameter FILT_CYC, default 1: consecutive synced cycles a new level must hold before it is accepted (>=1).
REQ-004 Parameter CNT_W, default 8: width of each per-channel event counter (>=1).
REQ-005 Port clk  input  1: clock, all state rising-edge.
REQ-006 Port reset_n  input  1: reset, asynchronous, active-low.
REQ-007 Port i_data  input  N_CH: asynchronous event inputs, bit c = channel c.
REQ-008 Port i_mode  input  2*N_CH: per-channel edge mode, bits [2c+1:2c]; 00 off, 01 rising, 10 falling, 11 both.
REQ-009 Port i_clr  input  N_CH: per-channel sticky-flag clear, level-sampled each cycle.
REQ-010 Port i_cnt_clr  input  1: synchronous clear of all event counters.
REQ-011 Port i_irq_en  input  N_CH: per-channel interrupt enable.
REQ-012 Port o_event  output  N_CH: registered one-cycle pulse per qualified event.
REQ-013 Port o_sticky  output  N_CH: registered event-seen flags.
REQ-014 Port o_count  output  N_CH*CNT_W: per-channel counters, channel c at [c*CNT_W +: CNT_W].
REQ-015 Port o_irq  output  1: OR over c of (o_sticky[c] & i_irq_en[c]), combinational from registers.

Function
REQ-016 Each channel shall pass i_data[c] through SYNC_STAGES flops; last stage = synced level s[c].
REQ-017 Each channel shall hold filtered level f[c] and filter counter; s==f -> counter to 0; s!=f and counter==FILT_CYC-1 -> f<=s, counter to 0; otherwise counter+1.
REQ-018 A glitch on s shorter than FILT_CYC cycles shall not change f and shall produce no event.
REQ-019 Qualified event on channel c: the clock edge at which f[c] changes, with 0->1 qualified in modes 01/11 and 1->0 qualified in modes 10/11.
REQ-020 i_mode shall be evaluated at the edge at which f changes; mode changes take effect immediately, with no flush.
REQ-021 o_event[c] shall be high for exactly the one cycle following a qualified-event edge; back-to-back accepted changes produce separate pulses.
REQ-022 Latency: i_data changes and is stable before edge E0 -> s changes at edge E0+SYNC_STAGES-1 -> o_event high after edge E0+SYNC_STAGES-1+FILT_CYC (defaults: after E2).
REQ-023 o_sticky[c] shall set on a qualified event and clear when i_clr[c]=1; simultaneous event and clear leaves it 1.
REQ-024 Counter c shall increment by 1 per qualified event and saturate at 2^CNT_W-1, never wrapping.
REQ-025 i_cnt_clr=1 shall zero all counters; simultaneous clear and event on channel c yields count 1.
REQ-026 Channels shall be fully independent; simultaneous events on any channel combination are all captured.

Reset
REQ-027 reset_n low shall asynchronously clear all synchroniser flops, f, filter counters, o_event, o_sticky, o_count to 0; o_irq then 0.
REQ-028 After reset release with i_data[c] held 1, channel c shall see a 0->1 change (rising event) at the latency of REQ-022.
REQ-029 Reset asserted mid-filter or mid-pulse shall abort it; no event is generated from pre-reset state.

Verification
REQ-030 Defaults, mode=01 on ch0, i_data[0] 0->1 before E0 -> o_event[0]=1 only after E2, o_sticky[0]=1, count0=1, o_irq=1 with i_irq_en[0]=1.
REQ-031 FILT_CYC=3, 2-cycle high glitch on ch1 (mode 11) -> no o_event, count1=0; 4-cycle high pulse -> two events, count1=2.
REQ-032 Mode 10 on ch2, rise then fall -> one pulse on the fall only; mode 00 -> no pulses, sticky/count unchanged.
REQ-033 CNT_W=2, 5 events on ch3 -> count3 sequence 1,2,3,3,3; i_cnt_clr coincident with 6th event -> count3=1.
REQ-034 i_clr[0] asserted on same edge as ch0 event -> o_sticky[0] stays 1; clr alone next cycle -> 0, o_irq=0.
REQ-035 reset_n pulsed low while ch0 filter counting and o_event[1] high -> all outputs 0 immediately, no residual event after release with inputs low.

Source files
------------

// File: rtl/event_detector_multi.sv
// Multi-channel asynchronous event detector: synchroniser, glitch filter and
// edge qualification per channel, with sticky flags, saturating counters and an irq.
module event_detector_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         i_data,
  input  logic [2*N_CH-1:0]       i_mode,
  input  logic [N_CH-1:0]         i_clr,
  input  logic                    i_cnt_clr,
  input  logic [N_CH-1:0]         i_irq_en,
  output logic [N_CH-1:0]         o_event,
  output logic [N_CH-1:0]         o_sticky,
  output logic [N_CH*CNT_W-1:0]   o_count,
  output logic                    o_irq
);

  localparam int unsigned      FC_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_s;
  logic [N_CH-1:0]  filt_q, filt_d;
  logic [FC_W-1:0]  fcnt_q [N_CH];
  logic [FC_W-1:0]  fcnt_d [N_CH];
  logic [N_CH-1:0]  event_q, event_d;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];

  // Synchroniser chain; the last stage is the synced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_data;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Filter, edge qualification, sticky and saturating counter per channel.
  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = fcnt_q;
    event_d  = '0;
    sticky_d = sticky_q & ~i_clr;
    count_d  = count_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (sync_s[c] == filt_q[c]) begin
        fcnt_d[c] = '0;
      end else if (fcnt_q[c] == FC_LAST) begin
        filt_d[c]  = sync_s[c];
        fcnt_d[c]  = '0;
        event_d[c] = sync_s[c] ? i_mode[2*c] : i_mode[2*c+1];
      end else begin
        fcnt_d[c] = fcnt_q[c] + FC_W'(1);
      end

      if (event_d[c]) sticky_d[c] = 1'b1;

      if (i_cnt_clr) begin
        count_d[c] = event_d[c] ? CNT_W'(1) : '0;
      end else if (event_d[c] && (count_q[c] != CNT_MAX)) begin
        count_d[c] = count_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q   <= '0;
      event_q  <= '0;
      sticky_q <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        fcnt_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else begin
      filt_q   <= filt_d;
      event_q  <= event_d;
      sticky_q <= sticky_d;
      for (int unsigned c = 0; c < N_CH; c++) begin
        fcnt_q[c]  <= fcnt_d[c];
        count_q[c] <= count_d[c];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign o_count[g*CNT_W +: CNT_W] = count_q[g];
  end

  assign o_event  = event_q;
  assign o_sticky = sticky_q;
  assign o_irq    = |(sticky_q & i_irq_en);

endmodule
